// File: rtl/rr_grant_collector_pkg.sv
// Shared types and helpers for the round-robin grant collector.
// Channel count, index width, FIFO entry layout and grant-vector decoding.
package rr_grant_collector_pkg;

    localparam int N_CH    = 4;
    localparam int CH_W    = 2;
    localparam int DW_DFLT = 32;

    typedef struct packed {
        logic [CH_W-1:0]    chan;
        logic [DW_DFLT-1:0] data;
    } entry_t;

    function automatic logic is_onehot(input logic [N_CH-1:0] v);
        logic [N_CH-1:0] v_m1;
        v_m1 = v - {{(N_CH-1){1'b0}}, 1'b1};
        return (v != {N_CH{1'b0}}) && ((v & v_m1) == {N_CH{1'b0}});
    endfunction

    function automatic logic [CH_W-1:0] onehot_to_idx(input logic [N_CH-1:0] v);
        logic [CH_W-1:0] idx;
        idx = {CH_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (v[i]) begin
                idx = CH_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_collector_fifo.sv
// Synchronous FIFO with registered storage; head is read straight from storage.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module rr_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_an,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == {(AW+1){1'b0}});
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Write/read enables and next occupancy
    always_comb begin
        wr_en_s = push_i & (~full_o | pop_i);
        rd_en_s = pop_i & ~empty_o;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy registers
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rr_grant_collector.sv
// Collects arbiter grants into a FIFO, acks the granted requester and filters
// raw requests so a channel is not re-granted before it drops its request.
module rr_grant_collector
    import rr_grant_collector_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_an,
    input  logic [N_CH-1:0]      req,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic [N_CH-1:0]      arb_req,
    input  logic [N_CH-1:0]      grant,
    output logic [N_CH-1:0]      ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [CH_W-1:0]      out_chan,
    output logic                 grant_err,
    output logic                 ovf_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [CH_W-1:0] chan;
        logic [DW-1:0]   data;
    } lentry_t;

    lentry_t         wr_entry_s;
    lentry_t         head_s;
    logic [CW-1:0]   count_s;
    logic            full_s;
    logic            empty_s;
    logic            pop_s;
    logic            push_s;
    logic            grant_multi_s;
    logic            space_s;
    logic [CW:0]     fill_s;
    logic [CH_W-1:0] grant_idx_s;

    logic [N_CH-1:0] pend_q,      pend_d;
    logic [N_CH-1:0] ack_q,       ack_d;
    logic            grant_err_q, grant_err_d;
    logic            ovf_err_q,   ovf_err_d;

    // Grant decode, request filter and next-state for flags and ack
    always_comb begin
        push_s        = is_onehot(grant);
        grant_multi_s = (grant != {N_CH{1'b0}}) & ~push_s;
        grant_idx_s   = onehot_to_idx(grant);
        pop_s         = ~empty_s & out_ready;
        // Pop is deliberately ignored so the grant already in flight always fits.
        fill_s        = {1'b0, count_s} + {{CW{1'b0}}, push_s};
        space_s       = (fill_s < (CW+1)'(DEPTH));
        arb_req       = req & ~pend_q & ~grant & {N_CH{space_s}};

        wr_entry_s.chan = grant_idx_s;
        wr_entry_s.data = in_data[grant_idx_s*DW +: DW];

        pend_d = grant | (pend_q & req);
        if (push_s && (!full_s || pop_s)) begin
            ack_d = grant;
        end else begin
            ack_d = {N_CH{1'b0}};
        end
        grant_err_d = grant_err_q | grant_multi_s;
        ovf_err_d   = ovf_err_q | (push_s & full_s & ~pop_s);
    end

    // Pending, ack and sticky error registers
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            pend_q      <= {N_CH{1'b0}};
            ack_q       <= {N_CH{1'b0}};
            grant_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            ack_q       <= ack_d;
            grant_err_q <= grant_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    rr_sync_fifo #(
        .WIDTH ($bits(lentry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_an  (rst_an),
        .push_i  (push_s),
        .data_i  (wr_entry_s),
        .pop_i   (pop_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s),
        .head_o  (head_s)
    );

    assign ack       = ack_q;
    assign grant_err = grant_err_q;
    assign ovf_err   = ovf_err_q;
    assign out_valid = ~empty_s;
    assign out_data  = head_s.data;
    assign out_chan  = head_s.chan;

endmodule

// File: tb/tb_rr_grant_collector.sv
// Directed bench for rr_grant_collector: the bench plays the arbiter and consumer
// and checks every observable output against hand-computed values.
module tb_rr_grant_collector;

    logic         clk;
    logic         rst_an;
    logic [3:0]   req;
    logic [127:0] in_data;
    logic [3:0]   arb_req;
    logic [3:0]   grant;
    logic [3:0]   ack;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_chan;
    logic         grant_err;
    logic         ovf_err;

    int checks;
    int errors;

    rr_grant_collector #(.DW(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_an    (rst_an),
        .req       (req),
        .in_data   (in_data),
        .arb_req   (arb_req),
        .grant     (grant),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .grant_err (grant_err),
        .ovf_err   (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [1:0] ch, input logic [31:0] d);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_chan"},  {30'd0, out_chan},  {30'd0, ch});
        chk({tag, "_data"},  out_data,           d);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_an    = 1'b0;
        req       = 4'b0000;
        grant     = 4'b0000;
        out_ready = 1'b0;
        in_data   = 128'd0;

        // Reset state
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ack",   {28'd0, ack},       32'd0);
        chk("rst_data",  out_data,           32'd0);
        chk("rst_errs",  {30'd0, grant_err, ovf_err}, 32'd0);
        rst_an = 1'b1;
        tick();

        // Single request
        req     = 4'b0001;
        in_data = {32'd0, 32'd0, 32'd0, 32'hA5A5A5A5};
        #1 chk("t1_arbreq_pre", {28'd0, arb_req}, 32'h1);
        grant = 4'b0001;
        #1 chk("t1_arbreq_gnt", {28'd0, arb_req}, 32'h0);
        tick();
        grant = 4'b0000;
        #1;
        chk("t1_ack", {28'd0, ack}, 32'h1);
        chk_head("t1_head", 2'd0, 32'hA5A5A5A5);
        chk("t1_arbreq_pend", {28'd0, arb_req}, 32'h0);
        tick();
        chk("t1_ack_pulse", {28'd0, ack}, 32'h0);
        chk("t1_arbreq_held", {28'd0, arb_req}, 32'h0);
        req       = 4'b0000;
        out_ready = 1'b1;
        tick();
        chk("t1_popped", {31'd0, out_valid}, 32'd0);
        req = 4'b0001;
        #1 chk("t1_arbreq_rearm", {28'd0, arb_req}, 32'h1);
        req = 4'b0000;

        // Back-to-back grants with out_ready=1
        in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        grant = 4'b0001; tick();
        grant = 4'b0010;
        chk("t2_ack0", {28'd0, ack}, 32'h1);
        chk_head("t2_h0", 2'd0, 32'h11111111);
        tick();
        grant = 4'b0100;
        chk("t2_ack1", {28'd0, ack}, 32'h2);
        chk_head("t2_h1", 2'd1, 32'h22222222);
        tick();
        grant = 4'b1000;
        chk("t2_ack2", {28'd0, ack}, 32'h4);
        chk_head("t2_h2", 2'd2, 32'h33333333);
        tick();
        grant = 4'b0000;
        chk("t2_ack3", {28'd0, ack}, 32'h8);
        chk_head("t2_h3", 2'd3, 32'h44444444);
        tick();
        chk("t2_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure fill: arb_req follows space and pend
        out_ready = 1'b0;
        req   = 4'b1111;
        grant = 4'b0001; #1 chk("t3_arb1", {28'd0, arb_req}, 32'hE); tick();
        grant = 4'b0010; #1 chk("t3_arb2", {28'd0, arb_req}, 32'hC); tick();
        grant = 4'b0100; #1 chk("t3_arb3", {28'd0, arb_req}, 32'h8); tick();
        grant = 4'b1000; #1 chk("t3_arb4", {28'd0, arb_req}, 32'h0); tick();
        grant = 4'b0000;
        req   = 4'b0000;
        chk_head("t3_full_head", 2'd0, 32'h11111111);
        chk("t3_no_ovf", {31'd0, ovf_err}, 32'd0);
        tick();
        req = 4'b1111;
        #1 chk("t3_arb_nospace", {28'd0, arb_req}, 32'h0);
        out_ready = 1'b1;
        chk_head("t3_d0", 2'd0, 32'h11111111);
        tick();
        chk("t3_arb_reassert", {28'd0, arb_req}, 32'hF);
        chk_head("t3_d1", 2'd1, 32'h22222222);
        tick();
        chk_head("t3_d2", 2'd2, 32'h33333333);
        tick();
        chk_head("t3_d3", 2'd3, 32'h44444444);
        tick();
        chk("t3_empty", {31'd0, out_valid}, 32'd0);
        req       = 4'b0000;
        out_ready = 1'b0;

        // Forced grant into a full FIFO
        grant = 4'b0001; tick();
        grant = 4'b0010; tick();
        grant = 4'b0100; tick();
        grant = 4'b1000; tick();
        grant = 4'b0100; tick();
        chk("t4_ovf_ack", {28'd0, ack}, 32'h0);
        chk("t4_ovf_err", {31'd0, ovf_err}, 32'd1);
        chk_head("t4_unchanged", 2'd0, 32'h11111111);
        in_data   = {32'h44444444, 32'h55555555, 32'h22222222, 32'h11111111};
        out_ready = 1'b1;
        tick();
        grant = 4'b0000;
        chk("t4_pushpop_ack", {28'd0, ack}, 32'h4);
        chk_head("t4_d1", 2'd1, 32'h22222222);
        tick();
        chk_head("t4_d2", 2'd2, 32'h33333333);
        tick();
        chk_head("t4_d3", 2'd3, 32'h44444444);
        tick();
        chk_head("t4_d4", 2'd2, 32'h55555555);
        tick();
        chk("t4_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Multi-hot grant
        grant = 4'b0011; tick();
        grant = 4'b0000;
        chk("t5_ack", {28'd0, ack}, 32'h0);
        chk("t5_err", {31'd0, grant_err}, 32'd1);
        chk("t5_nopush", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t5_err_sticky", {31'd0, grant_err}, 32'd1);

        // Reset mid-operation
        req   = 4'b0110;
        grant = 4'b0001; tick();
        grant = 4'b0010; tick();
        grant = 4'b0100; tick();
        grant = 4'b0000;
        chk("t6_ack_before", {28'd0, ack}, 32'h4);
        #2;
        rst_an = 1'b0;
        req    = 4'b0000;
        #1;
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_ack",   {28'd0, ack},       32'h0);
        chk("t6_data",  out_data,           32'd0);
        chk("t6_chan",  {30'd0, out_chan},  32'd0);
        chk("t6_errs",  {30'd0, grant_err, ovf_err}, 32'd0);
        chk("t6_arbreq", {28'd0, arb_req},  32'h0);
        #1;
        rst_an = 1'b1;
        req    = 4'b0100;
        #1 chk("t6_arbreq_after", {28'd0, arb_req}, 32'h4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
